// File: rtl/eater_pkg.sv
// Shared definitions for the SAP-1 program loader: state encodings and RAM geometry
// common with the core.
package eater_pkg;

  localparam int RAM_DEPTH = 16;
  localparam int RAM_AW    = 4;
  localparam int DATA_W    = 8;

  localparam logic [DATA_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD,
    ST_CHECK,
    ST_ERROR
  } load_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/eater_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, LSB-first shifter.
// rx_valid / rx_frame_err are single-cycle pulses; rx_data is stable while rx_valid is high.
module eater_uart_rx
  import eater_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              uart_rx_i,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic              sync1_q, sync2_q, prev_q;
  rx_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= uart_rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[DATA_W-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          state_d = RX_IDLE;
          valid_d = sync2_q;
          err_d   = !sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_data      = shift_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = err_q;

endmodule

// File: rtl/eater_loader.sv
// UART program loader for the SAP-1 core: SYNC_BYTE then 16 bytes written to RAM addr 0..15,
// core held in reset meanwhile. Optional trailing checksum byte with EATER_LOADER_CHECKSUM_EN.
module eater_loader
  import eater_pkg::*;
#(
  parameter int                CLKS_PER_BIT = 104,
  parameter logic [DATA_W-1:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int                TIMEOUT_CLKS = 2 ** 20
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              uart_rx_i,
  output logic              load_we_o,
  output logic [RAM_AW-1:0] load_addr_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              cpu_reset_o,
  output logic              load_error_o
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [RAM_AW-1:0] LAST_ADDR = RAM_AW'(RAM_DEPTH - 1);

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_frame_err;

  eater_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .uart_rx_i   (uart_rx_i),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err)
  );

  load_state_t       state_q, state_d;
  logic [RAM_AW-1:0] cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              we_q, we_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              cpu_rst_q, cpu_rst_d;
`ifdef EATER_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      tmo_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
`ifdef EATER_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
`ifdef EATER_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef EATER_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      ST_RUN, ST_ERROR: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
`ifdef EATER_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      ST_LOAD: begin
        tmo_d = tmo_q + 1'b1;
        if (rx_frame_err) begin
          state_d = ST_ERROR;
        end else if (rx_valid) begin
          tmo_d  = '0;
          we_d   = 1'b1;
          addr_d = cnt_q;
          data_d = rx_data;
`ifdef EATER_LOADER_CHECKSUM_EN
          sum_d  = sum_q + rx_data;
          if (cnt_q == LAST_ADDR) state_d = ST_CHECK;
`else
          if (cnt_q == LAST_ADDR) state_d = ST_RUN;
`endif
          else cnt_d = cnt_q + 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERROR;
        end
      end
`ifdef EATER_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        tmo_d = tmo_q + 1'b1;
        if (rx_frame_err) begin
          state_d = ST_ERROR;
        end else if (rx_valid) begin
          state_d = (DATA_W'(sum_q + rx_data) == '0) ? ST_RUN : ST_ERROR;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERROR;
        end
      end
`endif
      default: state_d = ST_RUN;
    endcase
    // Error is a function of the state being entered, so SYNC_BYTE clears it on the same edge.
    err_d     = (state_d == ST_ERROR);
    cpu_rst_d = (state_q != ST_RUN);
  end

  assign load_we_o    = we_q;
  assign load_addr_o  = addr_q;
  assign load_data_o  = data_q;
  assign cpu_reset_o  = cpu_rst_q;
  assign load_error_o = err_q;

endmodule

// File: tb/tb_eater_loader.sv
// Randomized bench for eater_loader: a byte-level model of the load protocol predicts RAM writes
// and core-reset/error flags; every strobe cycle is checked against the expected write queue.
module tb_eater_loader;

  localparam int CPB = 4;
  localparam int TMO = 256;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       uart_rx_i = 1'b1;
  logic       load_we_o;
  logic [3:0] load_addr_o;
  logic [7:0] load_data_o;
  logic       cpu_reset_o;
  logic       load_error_o;

  eater_loader #(
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .uart_rx_i   (uart_rx_i),
    .load_we_o   (load_we_o),
    .load_addr_o (load_addr_o),
    .load_data_o (load_data_o),
    .cpu_reset_o (cpu_reset_o),
    .load_error_o(load_error_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int strobes_seen = 0;

  // Expected RAM writes as {addr, data}.
  logic [11:0] exp_q[$];

  // Protocol model: 0 = running, 1 = loading data, 2 = awaiting checksum, 3 = error.
  int         m_mode = 0;
  int         m_idx = 0;
  logic [7:0] m_sum = 8'h00;
  logic [7:0] frame_buf[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (!reset_i && load_we_o) begin
      strobes_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got addr %0h data %0h expected no write", load_addr_o,
                 load_data_o);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({load_addr_o, load_data_o} !== e) begin
          errors++;
          $display("FAIL strobe: got addr %0h data %0h expected addr %0h data %0h", load_addr_o,
                   load_data_o, e[11:8], e[7:0]);
        end
      end
    end
  end

  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      if (m_mode == 1 || m_mode == 2) m_mode = 3;
    end else begin
      case (m_mode)
        0, 3: if (b == 8'hA5) begin
          m_mode = 1;
          m_idx  = 0;
          m_sum  = 8'h00;
        end
        1: begin
          exp_q.push_back({4'(m_idx), b});
          m_sum = m_sum + b;
          if (m_idx == 15) begin
`ifdef EATER_LOADER_CHECKSUM_EN
            m_mode = 2;
`else
            m_mode = 0;
`endif
          end else m_idx++;
        end
        2: m_mode = (8'(m_sum + b) == 8'h00) ? 0 : 3;
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic quiet_check(input string name);
    chk({name, "_cpu_reset"}, 32'(cpu_reset_o), 32'(m_mode != 0));
    chk({name, "_load_error"}, 32'(load_error_o), 32'(m_mode == 3));
    chk({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    @(negedge clk_i);
    uart_rx_i = 1'b0;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (CPB) @(negedge clk_i);
    end
    // Model is updated before the stop bit so the write is queued before the DUT can emit it.
    model_byte(b, good);
    uart_rx_i = good;
    repeat (CPB) @(negedge clk_i);
    uart_rx_i = 1'b1;
    repeat (8) @(negedge clk_i);
  endtask

  task automatic send_frame_buf();
    logic [7:0] s;
    s = 8'h00;
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 16; i++) begin
      send_byte(frame_buf[i], 1'b1);
      s = s + frame_buf[i];
    end
`ifdef EATER_LOADER_CHECKSUM_EN
    send_byte(8'h00 - s, 1'b1);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
    if (n >= TMO && (m_mode == 1 || m_mode == 2)) m_mode = 3;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    chk("reset_cpu_reset", 32'(cpu_reset_o), 32'd1);
    chk("reset_we", 32'(load_we_o), 32'd0);
    chk("reset_addr", 32'(load_addr_o), 32'd0);
    chk("reset_data", 32'(load_data_o), 32'd0);
    chk("reset_error", 32'(load_error_o), 32'd0);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    m_mode = 0;
    exp_q.delete();
    @(posedge clk_i);
    #1;
    chk("release_cpu_reset", 32'(cpu_reset_o), 32'd0);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk_i);
    do_reset();

    // Sequential image 00..0F.
    base = strobes_seen;
    for (int i = 0; i < 16; i++) frame_buf[i] = 8'(i);
    send_byte(8'hA5, 1'b1);
    chk("sync_holds_core", 32'(cpu_reset_o), 32'd1);
    for (int i = 0; i < 16; i++) send_byte(frame_buf[i], 1'b1);
`ifdef EATER_LOADER_CHECKSUM_EN
    send_byte(8'h88, 1'b1);
`endif
    chk("seq_strobe_count", 32'(strobes_seen - base), 32'd16);
    chk("seq_cpu_released", 32'(cpu_reset_o), 32'd0);
    chk("seq_no_error", 32'(load_error_o), 32'd0);
    quiet_check("seq");

    // Non-sync bytes while running.
    base = strobes_seen;
    send_byte(8'h3C, 1'b1);
    send_byte(8'h5A, 1'b1);
    chk("run_junk_no_strobe", 32'(strobes_seen - base), 32'd0);
    chk("run_junk_cpu", 32'(cpu_reset_o), 32'd0);

    // Inter-byte timeout, then recovery.
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    idle(300);
    chk("timeout_error", 32'(load_error_o), 32'd1);
    chk("timeout_cpu", 32'(cpu_reset_o), 32'd1);
    for (int i = 0; i < 16; i++) frame_buf[i] = 8'($urandom_range(0, 255));
    send_frame_buf();
    chk("recover_error_clear", 32'(load_error_o), 32'd0);
    chk("recover_cpu", 32'(cpu_reset_o), 32'd0);
    quiet_check("recover");

    // Framing error mid-frame, then reset mid-frame and stray bytes.
    base = strobes_seen;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h42, 1'b0);
    chk("frame_err_no_strobe", 32'(strobes_seen - base), 32'd0);
    chk("frame_err_error", 32'(load_error_o), 32'd1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    do_reset();
    base = strobes_seen;
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    chk("post_reset_no_strobe", 32'(strobes_seen - base), 32'd0);
    quiet_check("post_reset");

`ifdef EATER_LOADER_CHECKSUM_EN
    for (int i = 0; i < 16; i++) frame_buf[i] = 8'(i + 1);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(frame_buf[i], 1'b1);
    send_byte(8'h78, 1'b1);
    chk("chk_good_cpu", 32'(cpu_reset_o), 32'd0);
    chk("chk_good_err", 32'(load_error_o), 32'd0);
    base = strobes_seen;
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(frame_buf[i], 1'b1);
    send_byte(8'h77, 1'b1);
    chk("chk_bad_strobes", 32'(strobes_seen - base), 32'd16);
    chk("chk_bad_err", 32'(load_error_o), 32'd1);
`endif

    // Randomized traffic.
    for (int f = 0; f < 14; f++) begin
      case ($urandom_range(0, 3))
        0: for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 164)), 1'b1);
        1: begin
          for (int i = 0; i < 16; i++) frame_buf[i] = 8'($urandom_range(0, 255));
          send_frame_buf();
        end
        2: begin
          int bad_at;
          bad_at = $urandom_range(0, 15);
          send_byte(8'hA5, 1'b1);
          for (int i = 0; i < 16; i++) send_byte(8'($urandom_range(0, 255)), i != bad_at);
        end
        default: begin
          for (int i = 0; i < 12; i++)
            send_byte(($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom_range(0, 255)),
                      $urandom_range(0, 15) != 0);
        end
      endcase
      idle($urandom_range(0, 10));
      quiet_check("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
